// File: rtl/sqrt_pkg.sv
// Shared types and widths for the round-robin square-root scheduler.
package sqrt_pkg;

  localparam int unsigned OPW   = 8;
  localparam int unsigned ROOTW = 4;
  localparam int unsigned REMW  = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/sqrt_rr_sched_if.sv
// Request/response bundle between client blocks and the square-root scheduler.
interface sqrt_rr_sched_if
  import sqrt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) ();

  logic [NREQ-1:0]     req_valid;
  logic [OPW*NREQ-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [ROOTW-1:0]    rsp_root;
  logic [REMW-1:0]     rsp_rem;
  logic                busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_root, rsp_rem, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_root, rsp_rem, busy
  );

endinterface

// File: rtl/sqrt_rr_sched_psqrt.sv
// Combinational 8-bit unsigned square-root array: u = floor(sqrt(p)).
module sqrt_rr_sched_psqrt
  import sqrt_pkg::*;
(
  input  logic [OPW-1:0]   p,
  output logic [ROOTW-1:0] u
);

  logic [ROOTW-1:0] acc;
  logic [ROOTW-1:0] cand;
  logic [OPW-1:0]   sq;

  // Decide one root bit per stage, MSB first, keeping it if the trial square fits.
  always_comb begin
    acc  = '0;
    cand = '0;
    sq   = '0;
    for (int i = ROOTW - 1; i >= 0; i--) begin
      cand = acc | (ROOTW'(1) << i);
      sq   = {4'b0, cand} * {4'b0, cand};
      if (sq <= p) acc = cand;
    end
    u = acc;
  end

endmodule

// File: rtl/sqrt_rr_sched.sv
// Round-robin scheduler sharing one psqrt array among NREQ requesters.
module sqrt_rr_sched
  import sqrt_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  sqrt_rr_sched_if.slave  bus
);

  state_e           state;
  logic [ID_W-1:0]  ptr;
  logic [OPW-1:0]   operand;
  logic [3:0]       cnt;
  logic [ID_W-1:0]  id_q;
  logic [ROOTW-1:0] root_q;
  logic [REMW-1:0]  rem_q;

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic [OPW-1:0]   gnt_data;
  logic [NREQ-1:0]  gnt_oh;
  logic [ID_W-1:0]  ptr_nxt;
  int unsigned      idx;

  logic [ROOTW-1:0] root_arr;
  logic [OPW-1:0]   sq;

  sqrt_rr_sched_psqrt u_psqrt (
    .p (operand),
    .u (root_arr)
  );

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    gnt_data = '0;
    gnt_oh   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt_data = bus.req_data[idx*OPW +: OPW];
      end
    end
    if (gnt_any) gnt_oh[gnt_id] = 1'b1;
    ptr_nxt = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  assign sq = {4'b0, root_arr} * {4'b0, root_arr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      ptr     <= '0;
      operand <= '0;
      cnt     <= '0;
      id_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (gnt_any) begin
            operand <= gnt_data;
            id_q    <= gnt_id;
            ptr     <= ptr_nxt;
            cnt     <= 4'(SETTLE_CYCLES - 1);
            state   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt == 4'd0) begin
            root_q <= root_arr;
            rem_q  <= REMW'({1'b0, operand} - {1'b0, sq});
            state  <= StResp;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state == StIdle && !reset) ? gnt_oh : '0;
  assign bus.rsp_valid = (state == StResp);
  assign bus.busy      = (state != StIdle);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_root  = root_q;
  assign bus.rsp_rem   = rem_q;

endmodule

// File: tb/tb_sqrt_rr_sched.sv
// Self-checking bench for sqrt_rr_sched against a transaction-level reference model.
module tb_sqrt_rr_sched;

  localparam int NREQ   = 4;
  localparam int ID_W   = 2;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sqrt_rr_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  sqrt_rr_sched #(.NREQ(NREQ), .ID_W(ID_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int mdl_ptr = 0;
  int op_tab [NREQ];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_root(input int p);
    int r = 0;
    while ((r + 1) * (r + 1) <= p) r++;
    return r;
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) bus.req_data[8*i +: 8] = 8'(op_tab[i]);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    reset   = 1'b0;
    mdl_ptr = 0;
  endtask

  // One full transaction: grant check, latency, optional backpressure, response check.
  task automatic serve(input logic [NREQ-1:0] mask, input int rdly, output int gid);
    int exp_g, n, p, r;
    drive_ops();
    bus.req_valid = mask;
    #1;
    exp_g = ref_grant(mask, mdl_ptr);
    gid   = exp_g;
    check_eq("idle_busy", int'(bus.busy), 0);
    check_eq("grant", int'(bus.req_ready), 1 << exp_g);
    step();
    mdl_ptr = (exp_g + 1) % NREQ;
    p = op_tab[exp_g];
    r = ref_root(p);
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      check_eq("settle_ready", int'(bus.req_ready), 0);
      step();
      n++;
    end
    check_eq("latency", n, SETTLE + 1);
    for (int c = 0; c < rdly; c++) begin
      check_eq("hold_valid", int'(bus.rsp_valid), 1);
      check_eq("hold_busy", int'(bus.busy), 1);
      check_eq("hold_ready", int'(bus.req_ready), 0);
      check_eq("hold_root", int'(bus.rsp_root), r);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("rsp_id", int'(bus.rsp_id), exp_g);
    check_eq("rsp_root", int'(bus.rsp_root), r);
    check_eq("rsp_rem", int'(bus.rsp_rem), p - r * r);
    step();
    bus.rsp_ready = 1'b0;
    check_eq("back_idle", int'(bus.busy), 0);
    check_eq("no_rsp", int'(bus.rsp_valid), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && $countones(bus.req_ready) > 1) check_eq("onehot", int'(bus.req_ready), 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    int seq [5];
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) op_tab[i] = 0;
    do_reset();

    check_eq("rst_ready", int'(bus.req_ready), 0);
    check_eq("rst_valid", int'(bus.rsp_valid), 0);
    check_eq("rst_id", int'(bus.rsp_id), 0);
    check_eq("rst_root", int'(bus.rsp_root), 0);
    check_eq("rst_rem", int'(bus.rsp_rem), 0);
    check_eq("rst_busy", int'(bus.busy), 0);

    // Single request: requester 1, operand 64.
    op_tab[1] = 64;
    serve(4'b0010, 0, g);
    check_eq("single_id", g, 1);

    // Sweep all operands on requester 2.
    for (int p = 0; p < 256; p++) begin
      op_tab[2] = p;
      serve(4'b0100, 0, g);
    end

    // Contention: all requesters valid continuously.
    do_reset();
    op_tab[0] = 4; op_tab[1] = 9; op_tab[2] = 16; op_tab[3] = 25;
    for (int t = 0; t < 5; t++) serve(4'b1111, 0, seq[t]);
    check_eq("cont_g0", seq[0], 0);
    check_eq("cont_g1", seq[1], 1);
    check_eq("cont_g2", seq[2], 2);
    check_eq("cont_g3", seq[3], 3);
    check_eq("cont_g4", seq[4], 0);

    // Backpressure for 5 cycles.
    op_tab[1] = 200;
    serve(4'b0010, 5, g);

    // Reset one cycle after a handshake discards the operation.
    do_reset();
    op_tab[2] = 99;
    drive_ops();
    bus.req_valid = 4'b0100;
    step();
    reset = 1'b1;
    step();
    check_eq("rstmid_valid", int'(bus.rsp_valid), 0);
    check_eq("rstmid_busy", int'(bus.busy), 0);
    reset         = 1'b0;
    bus.req_valid = '0;
    mdl_ptr       = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("rstmid_quiet", int'(bus.rsp_valid), 0);
    end
    op_tab[1] = 50; op_tab[3] = 7;
    serve(4'b1010, 0, g);
    check_eq("rstmid_lowest", g, 1);

    // Pointer wrap: move pointer to 3, then only requesters 3 and 0 valid.
    do_reset();
    op_tab[0] = 255; op_tab[2] = 17; op_tab[3] = 224;
    serve(4'b0100, 0, g);
    for (int t = 0; t < 3; t++) serve(4'b1001, 0, seq[t]);
    check_eq("wrap_g0", seq[0], 3);
    check_eq("wrap_g1", seq[1], 0);
    check_eq("wrap_g2", seq[2], 3);

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 80; t++) begin
      logic [NREQ-1:0] m;
      for (int i = 0; i < NREQ; i++) op_tab[i] = int'($urandom_range(0, 255));
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve(m, int'($urandom_range(0, 3)), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
